// File: rtl/fleet_controller.sv
// Alien formation sequencer: march/descend control, kill-based speed-up, round-robin fire scheduling.
// All outputs registered; fire_req held until fire_ack or withdrawal. Speed-up built only with FLEET_SPEEDUP_EN.
module fleet_controller #(
    parameter int          NUM_ALIENS    = 8,
    parameter int          SPRITE_WIDTH  = 16,
    parameter logic [15:0] LEFT_LIMIT    = 16'd8,
    parameter logic [15:0] RIGHT_LIMIT   = 16'd632,
    parameter logic [15:0] BASE_PERIOD   = 16'd1000,
    parameter logic [15:0] PERIOD_STEP   = 16'd100,
    parameter logic [15:0] MIN_PERIOD    = 16'd100,
    parameter logic [15:0] FIRE_INTERVAL = 16'd5000,
    parameter int          MAX_DESCENTS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     new_wave,
    input  logic [NUM_ALIENS-1:0]    alive_mask,
    input  logic [NUM_ALIENS*16-1:0] alien_x,
    input  logic                     fire_ack,
    output logic                     movement_direction,
    output logic [15:0]              movement_frequency,
    output logic                     step_down,
    output logic [NUM_ALIENS-1:0]    armed,
    output logic                     fire_req,
    output logic [15:0]              fire_origin_x,
    output logic                     cleared,
    output logic                     invaded
);
    localparam int IDX_W = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
    localparam int CNT_W = $clog2(MAX_DESCENTS + 1);
    localparam logic [CNT_W-1:0]      LAST_DESCENT = CNT_W'(MAX_DESCENTS - 1);
    localparam logic [15:0]           TIMER_LAST   = FIRE_INTERVAL - 16'd1;
    localparam logic [15:0]           HALF_SPRITE  = 16'(SPRITE_WIDTH / 2);
    localparam logic [NUM_ALIENS-1:0] ONE_HOT_0    = NUM_ALIENS'(1);

    typedef enum logic [2:0] {
        MARCH,
        DESCEND,
        SETTLE,
        CLEARED,
        INVADED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] descent_count;
    logic [IDX_W-1:0] pointer;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_inc;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             pick_vld;
    logic [15:0]      timer;
    logic [15:0]      period_nxt;
    logic [15:0]      min_x;
    logic [15:0]      max_x;
    logic [16:0]      right_extent;
    logic             at_right;
    logic             at_left;
    logic             at_edge;
    logic             all_dead;
    logic             fire_active;
    logic [15:0]      xs [NUM_ALIENS];

    for (genvar g = 0; g < NUM_ALIENS; g++) begin : g_unpack
        assign xs[g] = alien_x[16*g +: 16];
    end

    // Formation extent considers live aliens only; dead slots keep stale x values.
    always_comb begin
        min_x = 16'hFFFF;
        max_x = 16'h0000;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            if (alive_mask[i]) begin
                if (xs[i] < min_x) min_x = xs[i];
                if (xs[i] > max_x) max_x = xs[i];
            end
        end
    end

    assign right_extent = {1'b0, max_x} + 17'(SPRITE_WIDTH);
    assign at_right     = right_extent >= {1'b0, RIGHT_LIMIT};
    assign at_left      = min_x <= LEFT_LIMIT;
    assign at_edge      = movement_direction ? at_right : at_left;
    assign all_dead     = (alive_mask == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            MARCH:   if (at_edge) state_nxt = DESCEND;
            DESCEND: state_nxt = (descent_count == LAST_DESCENT) ? INVADED : SETTLE;
            // Both limits must be clear so a formation parked on an edge cannot re-trigger.
            SETTLE:  if (!at_right && !at_left) state_nxt = MARCH;
            CLEARED: state_nxt = CLEARED;
            INVADED: state_nxt = INVADED;
            default: state_nxt = MARCH;
        endcase
        if (all_dead && state != INVADED) state_nxt = CLEARED;
    end

    assign fire_active = (state == MARCH || state == DESCEND || state == SETTLE) &&
                         (state_nxt != CLEARED) && (state_nxt != INVADED);

    // First live alien at or after the round-robin pointer; lowest offset wins.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_ALIENS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(pointer) + k) % NUM_ALIENS);
            if (alive_mask[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign sel_inc = (int'(sel_idx) == NUM_ALIENS - 1) ? '0 : sel_idx + IDX_W'(1);

`ifdef FLEET_SPEEDUP_EN
    int kills;
    int period_calc;
    always_comb begin
        kills = NUM_ALIENS;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            if (alive_mask[i]) kills = kills - 1;
        end
        period_calc = int'(BASE_PERIOD) - kills * int'(PERIOD_STEP);
        if (period_calc < int'(MIN_PERIOD)) period_calc = int'(MIN_PERIOD);
    end
    assign period_nxt = 16'(period_calc);
`else
    assign period_nxt = BASE_PERIOD;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            movement_frequency <= BASE_PERIOD;
        end else begin
            movement_frequency <= period_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= MARCH;
            movement_direction <= 1'b1;
            step_down          <= 1'b0;
            descent_count      <= '0;
            cleared            <= 1'b0;
            invaded            <= 1'b0;
            fire_req           <= 1'b0;
            armed              <= '0;
            sel_idx            <= '0;
            pointer            <= '0;
            timer              <= '0;
            fire_origin_x      <= '0;
        end else if (new_wave) begin
            state              <= MARCH;
            movement_direction <= 1'b1;
            step_down          <= 1'b0;
            descent_count      <= '0;
            cleared            <= 1'b0;
            invaded            <= 1'b0;
            fire_req           <= 1'b0;
            armed              <= '0;
            pointer            <= '0;
            timer              <= '0;
        end else begin
            state     <= state_nxt;
            cleared   <= (state_nxt == CLEARED);
            invaded   <= (state_nxt == INVADED);
            step_down <= 1'b0;
            if (state == DESCEND && state_nxt != CLEARED) begin
                step_down          <= 1'b1;
                movement_direction <= ~movement_direction;
                descent_count      <= descent_count + CNT_W'(1);
            end

            if (!fire_active) begin
                fire_req <= 1'b0;
                armed    <= '0;
                timer    <= '0;
            end else if (fire_req) begin
                if (fire_ack) begin
                    fire_req <= 1'b0;
                    armed    <= '0;
                    pointer  <= sel_inc;
                    timer    <= '0;
                end else if (!alive_mask[sel_idx]) begin
                    // Shooter died before the shot left: withdraw, keep the pointer.
                    fire_req <= 1'b0;
                    armed    <= '0;
                    timer    <= '0;
                end else begin
                    fire_origin_x <= xs[sel_idx] + HALF_SPRITE;
                end
            end else if (timer == TIMER_LAST) begin
                if (pick_vld) begin
                    fire_req      <= 1'b1;
                    armed         <= ONE_HOT_0 << pick_idx;
                    sel_idx       <= pick_idx;
                    fire_origin_x <= xs[pick_idx] + HALF_SPRITE;
                end
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fleet_controller.sv
// Bench for fleet_controller: table vectors, directed corner sequences and random traffic vs a behavioural model.
module tb_fleet_controller;
    localparam int N = 4;
    localparam int S_MARCH = 0, S_DESCEND = 1, S_SETTLE = 2, S_CLEARED = 3, S_INVADED = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_wave;
    logic [3:0]  alive_mask;
    logic [63:0] alien_x;
    logic        fire_ack;
    logic        movement_direction;
    logic [15:0] movement_frequency;
    logic        step_down;
    logic [3:0]  armed;
    logic        fire_req;
    logic [15:0] fire_origin_x;
    logic        cleared;
    logic        invaded;

    fleet_controller #(
        .NUM_ALIENS(4), .SPRITE_WIDTH(16), .LEFT_LIMIT(16'd8), .RIGHT_LIMIT(16'd632),
        .BASE_PERIOD(16'd100), .PERIOD_STEP(16'd20), .MIN_PERIOD(16'd30),
        .FIRE_INTERVAL(16'd50), .MAX_DESCENTS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .new_wave(new_wave), .alive_mask(alive_mask),
        .alien_x(alien_x), .fire_ack(fire_ack), .movement_direction(movement_direction),
        .movement_frequency(movement_frequency), .step_down(step_down), .armed(armed),
        .fire_req(fire_req), .fire_origin_x(fire_origin_x), .cleared(cleared), .invaded(invaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the fleet as described behaviourally.
    int m_state, m_dir, m_cnt, m_freq, m_step, m_req, m_armed, m_sel, m_ptr, m_timer, m_origin;
    int m_cleared, m_invaded;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int xval(input int i);
        return int'((alien_x >> (16 * i)) & 64'hFFFF);
    endfunction

    function automatic bit is_alive(input int i);
        return ((int'(alive_mask) >> i) & 1) == 1;
    endfunction

    task automatic model_edge();
        int  minx, maxx, kills, nxt;
        bit  atr, atl, hit, active, found;
        kills = 0;
        for (int i = 0; i < N; i++) if (!is_alive(i)) kills++;
`ifdef FLEET_SPEEDUP_EN
        m_freq = (100 - 20 * kills < 30) ? 30 : 100 - 20 * kills;
`else
        m_freq = 100;
`endif
        if (!rst_n) begin
            m_freq = 100; m_state = S_MARCH; m_dir = 1; m_cnt = 0; m_step = 0; m_req = 0;
            m_armed = 0; m_sel = 0; m_ptr = 0; m_timer = 0; m_origin = 0; m_cleared = 0; m_invaded = 0;
            return;
        end
        if (new_wave) begin
            m_state = S_MARCH; m_dir = 1; m_cnt = 0; m_step = 0; m_req = 0; m_armed = 0;
            m_ptr = 0; m_timer = 0; m_cleared = 0; m_invaded = 0;
            return;
        end
        minx = 65535;
        maxx = 0;
        for (int i = 0; i < N; i++) begin
            if (is_alive(i)) begin
                if (xval(i) < minx) minx = xval(i);
                if (xval(i) > maxx) maxx = xval(i);
            end
        end
        atr = (maxx + 16 >= 632);
        atl = (minx <= 8);
        hit = (m_dir == 1) ? atr : atl;
        nxt = m_state;
        if (m_state == S_MARCH && hit) nxt = S_DESCEND;
        if (m_state == S_DESCEND) nxt = (m_cnt + 1 == 3) ? S_INVADED : S_SETTLE;
        if (m_state == S_SETTLE && !atr && !atl) nxt = S_MARCH;
        if (alive_mask == 4'b0000 && m_state != S_INVADED) nxt = S_CLEARED;
        m_step = 0;
        if (m_state == S_DESCEND && nxt != S_CLEARED) begin
            m_step = 1;
            m_dir  = 1 - m_dir;
            m_cnt++;
        end
        active = (m_state <= S_SETTLE) && (nxt <= S_SETTLE);
        if (!active) begin
            m_req = 0; m_armed = 0; m_timer = 0;
        end else if (m_req == 1) begin
            if (fire_ack) begin
                m_req = 0; m_armed = 0; m_ptr = (m_sel + 1) % N; m_timer = 0;
            end else if (!is_alive(m_sel)) begin
                m_req = 0; m_armed = 0; m_timer = 0;
            end else begin
                m_origin = (xval(m_sel) + 8) & 16'hFFFF;
            end
        end else if (m_timer == 49) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && is_alive((m_ptr + k) % N)) begin
                    m_sel = (m_ptr + k) % N;
                    found = 1;
                end
            end
            m_req    = 1;
            m_armed  = 1 << m_sel;
            m_origin = (xval(m_sel) + 8) & 16'hFFFF;
        end else begin
            m_timer++;
        end
        m_state   = nxt;
        m_cleared = (nxt == S_CLEARED) ? 1 : 0;
        m_invaded = (nxt == S_INVADED) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("direction", int'(movement_direction), m_dir);
        chk("frequency", int'(movement_frequency), m_freq);
        chk("step_down", int'(step_down), m_step);
        chk("fire_req", int'(fire_req), m_req);
        chk("armed", int'(armed), m_armed);
        chk("cleared", int'(cleared), m_cleared);
        chk("invaded", int'(invaded), m_invaded);
        if (m_req != 0) chk("fire_origin_x", int'(fire_origin_x), m_origin);
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        alien_x = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic pulse_new_wave();
        new_wave = 1'b1;
        tick();
        new_wave = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int cycles);
        cycles = 0;
        while (fire_req !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (fire_req !== 1'b1) chk("fire_req_timeout", int'(fire_req), 1);
    endtask

    task automatic ack_shot();
        fire_ack = 1'b1;
        tick();
        fire_ack = 1'b0;
        chk("ack_drops_req", int'(fire_req), 0);
        chk("ack_drops_armed", int'(armed), 0);
    endtask

    task automatic hit_edge(input bit right);
        int cycles;
        if (right) set_x(568, 584, 600, 616);
        else       set_x(8, 24, 40, 56);
        cycles = 0;
        while (step_down !== 1'b1 && cycles < 10) begin
            tick();
            cycles++;
        end
        chk("edge_to_step_down", cycles, 2);
    endtask

    typedef struct {
        logic [3:0] mask;
        int         freq_spd;
        int         freq_fix;
        int         clr;
    } vec_t;
    vec_t vec [8];

    initial begin
        int c;
        int pulses;
        vec[0] = '{4'b1111, 100, 100, 0};
        vec[1] = '{4'b0111,  80, 100, 0};
        vec[2] = '{4'b0011,  60, 100, 0};
        vec[3] = '{4'b0001,  40, 100, 0};
        vec[4] = '{4'b1000,  40, 100, 0};
        vec[5] = '{4'b1110,  80, 100, 0};
        vec[6] = '{4'b1111, 100, 100, 0};
        vec[7] = '{4'b0000,  30, 100, 1};

        rst_n = 1'b0; new_wave = 1'b0; fire_ack = 1'b0; alive_mask = 4'b1111;
        set_x(100, 100, 100, 100);
        repeat (3) tick();
        chk("rst_direction", int'(movement_direction), 1);
        chk("rst_frequency", int'(movement_frequency), 100);
        chk("rst_step_down", int'(step_down), 0);
        chk("rst_fire_req", int'(fire_req), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_cleared", int'(cleared), 0);
        chk("rst_invaded", int'(invaded), 0);
        rst_n = 1'b1;

        // Speed table: one cycle from alive_mask change to movement_frequency.
        for (int i = 0; i < 8; i++) begin
            alive_mask = vec[i].mask;
            tick();
`ifdef FLEET_SPEEDUP_EN
            chk("table_frequency", int'(movement_frequency), vec[i].freq_spd);
`else
            chk("table_frequency", int'(movement_frequency), vec[i].freq_fix);
`endif
            chk("table_cleared", int'(cleared), vec[i].clr);
        end

        // Right edge: single step_down two cycles after detection, no retrigger while parked.
        alive_mask = 4'b1111;
        pulse_new_wave();
        set_x(100, 200, 300, 600);
        for (int v = 604; v <= 612; v += 4) begin
            set_x(100, 200, 300, v);
            tick();
            chk("ramp_no_step", int'(step_down), 0);
        end
        set_x(100, 200, 300, 616);
        tick();
        chk("detect_cycle_step", int'(step_down), 0);
        chk("detect_cycle_dir", int'(movement_direction), 1);
        tick();
        chk("step_cycle_step", int'(step_down), 1);
        chk("step_cycle_dir", int'(movement_direction), 0);
        pulses = 0;
        repeat (8) begin
            tick();
            if (step_down === 1'b1) pulses++;
        end
        chk("parked_extra_pulses", pulses, 0);
        set_x(100, 200, 300, 400);
        tick();

        // Round-robin fire with alive=1010.
        pulse_new_wave();
        alive_mask = 4'b1010;
        wait_req(200, c);
        chk("fire_latency_1", c, 50);
        chk("shot1_armed", int'(armed), 4'b0010);
        chk("shot1_origin", int'(fire_origin_x), 208);
        ack_shot();
        wait_req(200, c);
        chk("fire_latency_2", c, 50);
        chk("shot2_armed", int'(armed), 4'b1000);
        chk("shot2_origin", int'(fire_origin_x), 408);
        ack_shot();
        wait_req(200, c);
        chk("shot3_wrap_armed", int'(armed), 4'b0010);
        ack_shot();

        // Armed alien dies with no ack: withdrawal, pointer kept.
        alive_mask = 4'b1111;
        wait_req(200, c);
        chk("shot4_armed", int'(armed), 4'b0100);
        alive_mask = 4'b1011;
        tick();
        chk("withdraw_req", int'(fire_req), 0);
        chk("withdraw_armed", int'(armed), 0);
        wait_req(200, c);
        chk("refire_latency", c, 50);
        chk("refire_armed", int'(armed), 4'b1000);
        ack_shot();

        // Three descents end in invasion; new_wave recovers.
        alive_mask = 4'b1111;
        set_x(100, 200, 300, 400);
        pulse_new_wave();
        hit_edge(1'b1);
        set_x(100, 200, 300, 400);
        tick();
        hit_edge(1'b0);
        set_x(100, 200, 300, 400);
        tick();
        hit_edge(1'b1);
        chk("third_step_invaded", int'(invaded), 1);
        set_x(100, 200, 300, 400);
        repeat (60) begin
            tick();
            chk("invaded_armed_zero", int'(armed), 0);
        end
        chk("invaded_sticky", int'(invaded), 1);
        pulse_new_wave();
        chk("nw_invaded", int'(invaded), 0);
        chk("nw_direction", int'(movement_direction), 1);
        hit_edge(1'b1);
        chk("count_reset_no_invade", int'(invaded), 0);
        set_x(100, 200, 300, 400);
        tick();

        // All aliens die while a descent is pending and a shot is waiting.
        pulse_new_wave();
        wait_req(200, c);
        set_x(568, 584, 600, 616);
        tick();
        alive_mask = 4'b0000;
        tick();
        chk("clr_cleared", int'(cleared), 1);
        chk("clr_no_step", int'(step_down), 0);
        chk("clr_fire_req", int'(fire_req), 0);
        chk("clr_armed", int'(armed), 0);
        repeat (3) tick();
        chk("clr_sticky", int'(cleared), 1);

        // Random traffic against the model.
        alive_mask = 4'b1111;
        set_x(100, 200, 300, 400);
        pulse_new_wave();
        for (int n = 0; n < 3000; n++) begin
            new_wave = ($urandom_range(0, 299) == 0);
            fire_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) alive_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                for (int a = 0; a < N; a++) begin
                    int pick;
                    int v;
                    pick = int'($urandom_range(0, 8));
                    case (pick)
                        0: v = 0;   1: v = 8;   2: v = 9;   3: v = 200; 4: v = 400;
                        5: v = 615; 6: v = 616; 7: v = 630;
                        default: v = int'($urandom_range(0, 700));
                    endcase
                    alien_x[16*a +: 16] = 16'(v);
                end
            end
            tick();
        end
        new_wave = 1'b0;
        fire_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fleet_controller.md
# fleet_controller

Sequencer for the alien formation. Watches the alive mask and x positions of every alien, drives the shared `movement_direction` and `movement_frequency` inputs of all `alien` instances, and issues a one-cycle `step_down` pulse when the formation reaches a playfield edge. Also schedules alien fire: it picks one alive alien round-robin, raises its `armed` bit, and handshakes with the projectile block. It sits between the alien array and the game-state logic.

## Interface
- `NUM_ALIENS`, 8: number of alien instances controlled.
- `SPRITE_WIDTH`, 16: alien sprite width in pixels.
- `LEFT_LIMIT`, 16'd8: smallest allowed alien x.
- `RIGHT_LIMIT`, 16'd632: largest allowed x + SPRITE_WIDTH.
- `BASE_PERIOD`, 16'd1000: movement_frequency with no kills.
- `PERIOD_STEP`, 16'd100: period reduction per dead alien.
- `MIN_PERIOD`, 16'd100: lower saturation of movement_frequency.
- `FIRE_INTERVAL`, 16'd5000: cycles between shot requests.
- `MAX_DESCENTS`, 8: step-downs before invasion.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `new_wave` in 1: pulse; restarts fleet state (priority over all but reset).
- `alive_mask` in NUM_ALIENS: bit i = alien i alive.
- `alien_x` in NUM_ALIENS*16: flattened position_x, alien i at [16i+15:16i].
- `fire_ack` in 1: projectile block accepted the shot.
- `movement_direction` out 1: 0 left, 1 right.
- `movement_frequency` out 16: shared movement period.
- `step_down` out 1: one-cycle pulse; formation y += one row.
- `armed` out NUM_ALIENS: one-hot or zero; shooter select.
- `fire_req` out 1: shot request, held until ack or withdrawal.
- `fire_origin_x` out 16: x of armed alien + SPRITE_WIDTH/2.
- `cleared` out 1: all aliens dead.
- `invaded` out 1: descent count reached MAX_DESCENTS.

## Operation
- Edge extent computed combinationally over alive aliens only: min_x, max_x (unsigned 16-bit). At edge: dir=1 and max_x+SPRITE_WIDTH ≥ RIGHT_LIMIT (17-bit add), or dir=0 and min_x ≤ LEFT_LIMIT.
- FSM states: MARCH, DESCEND, SETTLE, CLEARED, INVADED.
- MARCH: at edge → DESCEND.
- DESCEND (1 cycle): step_down=1, direction toggles, descent_count+1; if new count = MAX_DESCENTS → INVADED, else → SETTLE.
- SETTLE: stays until the edge condition (new direction) is false and extent has moved off the limit, then → MARCH. A second edge is never detected in SETTLE.
- CLEARED: entered from any state when alive_mask==0 (takes priority over an edge in the same cycle). Sticky until new_wave.
- INVADED: terminal until new_wave. Movement outputs hold; armed=0.
- new_wave: next cycle state MARCH, direction=1, descent_count=0, fire timer=0, pointer=0, fire_req/armed cleared.
- Speed: kills = NUM_ALIENS − popcount(alive_mask). period = BASE_PERIOD − kills*PERIOD_STEP, computed 32-bit, saturated to MIN_PERIOD; registered.
- Fire scheduler (only in MARCH/SETTLE/DESCEND): timer counts to FIRE_INTERVAL−1. On expiry it selects the first alive index at or after pointer, wrapping. It then sets armed one-hot and fire_req=1, and the timer holds.
- fire_ack while fire_req=1: next cycle fire_req=0, armed=0, pointer=selected+1 mod NUM_ALIENS, timer restarts at 0.
- Armed alien dies while waiting with no ack that cycle: request withdrawn next cycle, pointer unchanged, timer restarts. Ack in the same cycle as death counts as fired.
- fire_ack with fire_req=0 is ignored.

## Timing
- Reset (rst_n=0 at clk edge) values:
  - state MARCH, direction 1, movement_frequency BASE_PERIOD.
  - step_down, fire_req, armed, cleared, invaded all 0.
  - descent_count 0, pointer 0, timer 0.
- All outputs registered. Edge detection → step_down: 2 cycles (MARCH detects, DESCEND asserts). Direction toggles on the same edge that step_down rises.
- Timer expiry → fire_req/armed: 1 cycle. fire_ack → fire_req low: 1 cycle.
- alive_mask change → movement_frequency update: 1 cycle. alive_mask==0 → cleared: 1 cycle.

## Configuration
- `FLEET_SPEEDUP_EN` defined: movement_frequency scales with kills as above.
- Undefined: movement_frequency fixed at BASE_PERIOD and the popcount/multiply logic is removed. All other behaviour is identical.

## Test plan
Bench parameters: NUM_ALIENS=4, BASE_PERIOD=100, PERIOD_STEP=20, MIN_PERIOD=30, FIRE_INTERVAL=50, MAX_DESCENTS=3.
- Reset, alive=4'b1111, alien_x ramps to max_x=616 → step_down single pulse 2 cycles later, direction 1→0, no second pulse while x stays 616.
- alive 4'b1111→4'b0011 → movement_frequency 60 next cycle. Then →4'b0001 → 40 (30 floor not yet hit). Macro undefined: stays 100.
- Timer expiry with alive=4'b1010, pointer 0 → armed=4'b0010 and fire_req. Ack → next shot armed=4'b1000, then wraps to 4'b0010.
- armed=4'b0100 pending, alive bit 2 drops with no ack → fire_req=0, armed=0 next cycle, new request 50 cycles later.
- Three edge hits → invaded=1 after third step_down, armed stays 0. new_wave → invaded=0, direction=1, descent_count 0.
- alive→0 in the same cycle as an edge → cleared=1, no step_down, fire_req=0.
